gpr_bank: RTL and testbench

- Parametrised bank of general-purpose registers; next generation of the single 24-bit load-only GPR.
- Sits between the datapath's C bus (write-back) and B bus (operand read).
- Adds multiple registers, addressed writes, increment/decrement, synchronous clear, async reset, and per-register zero flags.
- Serves as the datapath register file and as address/loop-counter registers.

---
 rtl/gpr_bank_if.sv | 26 ++
 rtl/gpr_bank.sv | 60 ++++++
 tb/tb_gpr_bank.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/gpr_bank_if.sv
// gpr_bank_if: C-bus write, inc/dec, clear and B-bus read signals of the GPR bank.
interface gpr_bank_if #(
  parameter int DATA_W   = 24,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 4
);
  logic                load_en;
  logic [SEL_W-1:0]    load_sel;
  logic [DATA_W-1:0]   C_bus;
  logic                inc_en;
  logic [SEL_W-1:0]    inc_sel;
  logic                dec_en;
  logic [SEL_W-1:0]    dec_sel;
  logic                clr_en;
  logic [SEL_W-1:0]    rd_sel;
  logic [DATA_W-1:0]   B_bus;
  logic [NUM_REGS-1:0] zero_flags;
  modport master (
    output load_en, load_sel, C_bus, inc_en, inc_sel, dec_en, dec_sel, clr_en, rd_sel,
    input  B_bus, zero_flags
  );
  modport slave (
    input  load_en, load_sel, C_bus, inc_en, inc_sel, dec_en, dec_sel, clr_en, rd_sel,
    output B_bus, zero_flags
  );
endinterface

// File: rtl/gpr_bank.sv
// gpr_bank: register file with addressed load, inc/dec, clear and per-register zero flags.
// Define GPR_BANK_BYPASS_EN to forward same-cycle load data (and clear) onto B_bus.
module gpr_bank #(
  parameter int                DATA_W    = 24,
  parameter int                NUM_REGS  = 8,
  parameter int                SEL_W     = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic        clk,
  input logic        rst_n,
  gpr_bank_if.slave  bus
);
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [DATA_W-1:0]   rd_val;
  logic [NUM_REGS-1:0] zf;
  logic                ld, inc, dec;
  always_comb begin
    ld  = 1'b0;
    inc = 1'b0;
    dec = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      ld  = bus.load_en && bus.load_sel == SEL_W'(i);
      inc = bus.inc_en && bus.inc_sel == SEL_W'(i);
      dec = bus.dec_en && bus.dec_sel == SEL_W'(i);
      regs_d[i] = bus.clr_en   ? '0 :
                  ld           ? bus.C_bus :
                  inc && !dec  ? regs_q[i] + 1'b1 :
                  dec && !inc  ? regs_q[i] - 1'b1 : regs_q[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end
  // Out-of-range read indices match no register and fall through to zero.
  always_comb begin
    rd_val = '0;
    zf     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.rd_sel == SEL_W'(i)) rd_val = regs_q[i];
      zf[i] = regs_q[i] == '0;
    end
  end
  assign bus.zero_flags = zf;
`ifdef GPR_BANK_BYPASS_EN
  logic hit;
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      hit = hit | (bus.load_en && bus.load_sel == SEL_W'(i) && bus.rd_sel == SEL_W'(i));
  end
  assign bus.B_bus = bus.clr_en ? '0 : hit ? bus.C_bus : rd_val;
`else
  assign bus.B_bus = rd_val;
`endif
endmodule

// File: tb/tb_gpr_bank.sv
// tb_gpr_bank: randomized and directed checks of gpr_bank against an array model.
module tb_gpr_bank;
  localparam int N = 6;
  localparam int W = 24;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [W-1:0] m [N];
  gpr_bank_if #(.DATA_W(W), .NUM_REGS(N), .SEL_W(4)) bus ();
  gpr_bank #(.DATA_W(W), .NUM_REGS(N), .SEL_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic drive(input bit ld, input int lsel, input logic [W-1:0] c,
                       input bit inc, input int isel, input bit dec, input int dsel,
                       input bit clr, input int rsel);
    bus.load_en = ld;  bus.load_sel = 4'(lsel); bus.C_bus = c;
    bus.inc_en = inc;  bus.inc_sel = 4'(isel);
    bus.dec_en = dec;  bus.dec_sel = 4'(dsel);
    bus.clr_en = clr;  bus.rd_sel = 4'(rsel);
  endtask

  task automatic idle(input int rsel);
    drive(0, 0, '0, 0, 0, 0, 0, 0, rsel);
  endtask

  // Model: clear wins; otherwise apply inc/dec (cancelling if same target), then load overrides.
  task automatic tick();
    logic [W-1:0] nm [N];
    bit same;
    nm = m;
    if (bus.clr_en) begin
      foreach (nm[i]) nm[i] = '0;
    end else begin
      same = bus.inc_en && bus.dec_en && bus.inc_sel == bus.dec_sel;
      if (bus.inc_en && !same && bus.inc_sel < N) nm[bus.inc_sel] = nm[bus.inc_sel] + 1;
      if (bus.dec_en && !same && bus.dec_sel < N) nm[bus.dec_sel] = nm[bus.dec_sel] - 1;
      if (bus.load_en && bus.load_sel < N) nm[bus.load_sel] = bus.C_bus;
    end
    @(posedge clk);
    m = nm;
    #1;
  endtask

  function automatic logic [W-1:0] exp_b();
`ifdef GPR_BANK_BYPASS_EN
    if (bus.clr_en) return '0;
    if (bus.load_en && bus.load_sel == bus.rd_sel && bus.load_sel < N) return bus.C_bus;
`endif
    return (bus.rd_sel < N) ? m[bus.rd_sel] : '0;
  endfunction

  function automatic logic [N-1:0] exp_zf();
    logic [N-1:0] z;
    foreach (m[i]) z[i] = (m[i] == 0);
    return z;
  endfunction

  task automatic test_reset();
    foreach (m[i]) m[i] = '0;
    idle(2);
    #1;
    total++; if (bus.B_bus !== '0) begin bad++; $display("FAIL reset_b got=%h exp=0", bus.B_bus); end
    total++; if (bus.zero_flags !== {N{1'b1}}) begin bad++; $display("FAIL reset_zf got=%b exp=%b", bus.zero_flags, {N{1'b1}}); end
    @(negedge clk); rst_n = 1'b1; #1;
    drive(1, 2, 24'h123456, 0, 0, 0, 0, 0, 2);
    tick();
    idle(2);
    total++; if (bus.B_bus !== 24'h123456) begin bad++; $display("FAIL reset_pre_load got=%h exp=123456", bus.B_bus); end
    #2 rst_n = 1'b0;
    foreach (m[i]) m[i] = '0;
    #1;
    total++; if (bus.B_bus !== '0) begin bad++; $display("FAIL reset_async_b got=%h exp=0", bus.B_bus); end
    total++; if (bus.zero_flags !== {N{1'b1}}) begin bad++; $display("FAIL reset_async_zf got=%b exp=%b", bus.zero_flags, {N{1'b1}}); end
    @(negedge clk); rst_n = 1'b1; #1;
  endtask

  task automatic test_load_read();
    drive(1, 3, 24'hABCDEF, 0, 0, 0, 0, 0, 3);
    #1;
    total++; if (bus.B_bus !== exp_b()) begin bad++; $display("FAIL load_pre_edge got=%h exp=%h", bus.B_bus, exp_b()); end
    tick();
    idle(3);
    #1;
    total++; if (bus.B_bus !== 24'hABCDEF) begin bad++; $display("FAIL load_read got=%h exp=abcdef", bus.B_bus); end
    total++; if (bus.zero_flags[3] !== 1'b0) begin bad++; $display("FAIL load_zf3 got=%b exp=0", bus.zero_flags[3]); end
  endtask

  task automatic test_wrap();
    drive(1, 1, 24'hFFFFFF, 0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, '0, 1, 1, 0, 0, 0, 1); tick();
    idle(1); #1;
    total++; if (bus.B_bus !== 24'h000000) begin bad++; $display("FAIL wrap_inc got=%h exp=000000", bus.B_bus); end
    total++; if (bus.zero_flags[1] !== 1'b1) begin bad++; $display("FAIL wrap_zf1 got=%b exp=1", bus.zero_flags[1]); end
    drive(0, 0, '0, 0, 0, 1, 1, 0, 1); tick();
    idle(1); #1;
    total++; if (bus.B_bus !== 24'hFFFFFF) begin bad++; $display("FAIL wrap_dec got=%h exp=ffffff", bus.B_bus); end
  endtask

  task automatic test_priority();
    drive(1, 4, 24'h5, 0, 0, 0, 0, 0, 4); tick();
    drive(1, 4, 24'h10, 1, 4, 0, 0, 0, 4); tick();
    idle(4); #1;
    total++; if (bus.B_bus !== 24'h10) begin bad++; $display("FAIL prio_load_inc got=%h exp=000010", bus.B_bus); end
    drive(0, 0, '0, 1, 4, 1, 4, 0, 4); tick();
    idle(4); #1;
    total++; if (bus.B_bus !== 24'h10) begin bad++; $display("FAIL prio_inc_dec got=%h exp=000010", bus.B_bus); end
    drive(1, 4, 24'h77, 1, 2, 1, 3, 1, 4); #1;
    total++; if (bus.B_bus !== exp_b()) begin bad++; $display("FAIL prio_clr_pre got=%h exp=%h", bus.B_bus, exp_b()); end
    tick();
    idle(4); #1;
    total++; if (bus.B_bus !== '0) begin bad++; $display("FAIL prio_clr got=%h exp=0", bus.B_bus); end
    total++; if (bus.zero_flags !== {N{1'b1}}) begin bad++; $display("FAIL prio_clr_zf got=%b exp=%b", bus.zero_flags, {N{1'b1}}); end
  endtask

  task automatic test_parallel();
    logic [W-1:0] want [3] = '{24'h7, 24'h1, 24'hFFFFFF};
    int sel [3] = '{0, 4, 5};
    drive(1, 0, 24'h7, 1, 4, 1, 5, 0, 0); tick();
    for (int k = 0; k < 3; k++) begin
      idle(sel[k]); #1;
      total++; if (bus.B_bus !== want[k]) begin bad++; $display("FAIL parallel_r%0d got=%h exp=%h", sel[k], bus.B_bus, want[k]); end
    end
  endtask

  task automatic test_out_of_range();
    drive(1, 7, 24'h999999, 1, 9, 1, 15, 0, 7); tick();
    for (int r = 0; r < N; r++) begin
      idle(r); #1;
      total++; if (bus.B_bus !== m[r]) begin bad++; $display("FAIL oor_r%0d got=%h exp=%h", r, bus.B_bus, m[r]); end
    end
    idle(7); #1;
    total++; if (bus.B_bus !== '0) begin bad++; $display("FAIL oor_read got=%h exp=0", bus.B_bus); end
    total++; if (bus.zero_flags !== exp_zf()) begin bad++; $display("FAIL oor_zf got=%b exp=%b", bus.zero_flags, exp_zf()); end
  endtask

  task automatic test_bypass();
    logic [W-1:0] want;
    drive(1, 2, 24'h111111, 0, 0, 0, 0, 0, 2); tick();
    drive(1, 2, 24'h55AA55, 0, 0, 0, 0, 0, 2); #1;
`ifdef GPR_BANK_BYPASS_EN
    want = 24'h55AA55;
`else
    want = 24'h111111;
`endif
    total++; if (bus.B_bus !== want) begin bad++; $display("FAIL bypass_same_cycle got=%h exp=%h", bus.B_bus, want); end
    total++; if (bus.zero_flags[2] !== 1'b0) begin bad++; $display("FAIL bypass_zf2 got=%b exp=0", bus.zero_flags[2]); end
    tick();
    idle(2); #1;
    total++; if (bus.B_bus !== 24'h55AA55) begin bad++; $display("FAIL bypass_after got=%h exp=55aa55", bus.B_bus); end
  endtask

  task automatic test_random();
    logic [W-1:0] c;
    for (int n = 0; n < 400; n++) begin
      c = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 24'h0 : 24'hFFFFFF) : W'($urandom);
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 7), c,
            $urandom_range(0, 1) == 0, $urandom_range(0, 7),
            $urandom_range(0, 1) == 0, $urandom_range(0, 7),
            $urandom_range(0, 15) == 0, $urandom_range(0, 15));
      #1;
      total++; if (bus.B_bus !== exp_b()) begin bad++; $display("FAIL rand_b n=%0d rd=%0d got=%h exp=%h", n, bus.rd_sel, bus.B_bus, exp_b()); end
      total++; if (bus.zero_flags !== exp_zf()) begin bad++; $display("FAIL rand_zf n=%0d got=%b exp=%b", n, bus.zero_flags, exp_zf()); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_wrap();
    test_priority();
    test_parallel();
    test_out_of_range();
    test_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
